axi_wr_arbiter: RTL and testbench



---
 rtl/axi_wr_arbiter_pkg.sv | 19 +
 rtl/axi_wr_arbiter_rr_pick.sv | 29 ++
 rtl/axi_wr_arbiter.sv | 111 +++++++++++
 tb/tb_axi_wr_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_arbiter_pkg.sv
// Shared types and helpers for the AXI write arbiter in front of the TLP chunk packer.
package axi_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // 9 bits so an awlen of 255 can count its final beat without wrapping
  localparam int BEAT_W = 9;

  function automatic int wrap_idx(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// Round-robin pick: rotate requests by ptr, take the lowest set bit, rotate the index back.
module axi_wr_arbiter_rr_pick
  import axi_wr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   sel;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rot[i] = req_i[IDX_W'(wrap_idx(i, int'(ptr_i), NUM_REQ))];
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) sel = IDX_W'(i);
  end

  assign found_o = |req_i;
  assign idx_o   = IDX_W'(wrap_idx(int'(sel), int'(ptr_i), NUM_REQ));

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI write arbiter: grants one requester per burst, forwards AW then W,
// regenerates WLAST from the latched length and flags requester framing errors.
module axi_wr_arbiter
  import axi_wr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int ID_WIDTH   = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 256,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  s_awvalid_i,
  output logic [NUM_REQ-1:0]                  s_awready_o,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]    s_awid_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  s_awaddr_i,
  input  logic [NUM_REQ-1:0][7:0]             s_awlen_i,
  input  logic [NUM_REQ-1:0]                  s_wvalid_i,
  output logic [NUM_REQ-1:0]                  s_wready_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  s_wdata_i,
  input  logic [NUM_REQ-1:0]                  s_wlast_i,
  output logic                                m_awvalid_o,
  input  logic                                m_awready_i,
  output logic [IDX_W+ID_WIDTH-1:0]           m_awid_o,
  output logic [ADDR_WIDTH-1:0]               m_awaddr_o,
  output logic [7:0]                          m_awlen_o,
  output logic                                m_wvalid_o,
  input  logic                                m_wready_i,
  output logic [DATA_WIDTH-1:0]               m_wdata_o,
  output logic                                m_wlast_o,
  output logic                                grant_valid_o,
  output logic [IDX_W-1:0]                    grant_idx_o,
  output logic                                err_wlast_o
);

  arb_state_t        state_q;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_q;
  logic [7:0]        len_q;
  logic [BEAT_W-1:0] beat_q;
  logic              err_q;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              wlast;
  logic              w_hs;

  axi_wr_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (s_awvalid_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign wlast    = (beat_q == {1'b0, len_q});
  assign w_hs     = m_wvalid_o && m_wready_i;

  // Valids depend only on registered state and the requester, never on m_*ready
  assign m_awvalid_o = (state_q == ADDR) && s_awvalid_i[grant_q];
  assign m_wvalid_o  = (state_q == DATA) && s_wvalid_i[grant_q];
  assign m_wlast_o   = (state_q == DATA) && wlast;
  assign m_awid_o    = {grant_q, s_awid_i[grant_q]};
  assign m_awaddr_o  = s_awaddr_i[grant_q];
  assign m_awlen_o   = s_awlen_i[grant_q];
  assign m_wdata_o   = s_wdata_i[grant_q];

  assign grant_valid_o = (state_q != IDLE);
  assign grant_idx_o   = grant_q;
  assign err_wlast_o   = err_q;

  always_comb begin
    s_awready_o = '0;
    s_wready_o  = '0;
    if (state_q == ADDR) s_awready_o[grant_q] = m_awready_i;
    if (state_q == DATA) s_wready_o[grant_q]  = m_wready_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (pick_found) begin
          grant_q <= pick_idx;
          len_q   <= s_awlen_i[pick_idx];
          beat_q  <= '0;
          state_q <= ADDR;
        end
        ADDR: if (m_awvalid_o && m_awready_i) state_q <= DATA;
        DATA: if (w_hs) begin
          beat_q <= beat_q + 1'b1;
          // Framing comes from len_q; the requester's wlast is only audited
          if (s_wlast_i[grant_q] != wlast) err_q <= 1'b1;
          if (wlast) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: 2-port instance for the main flows, 4-port for rotation and long bursts.
module tb_axi_wr_arbiter;
  localparam int N = 2, IW = 4, AW = 32, DW = 256;
  localparam int N4 = 4, DW4 = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic [N-1:0][IW-1:0]  s_awid;
  logic [N-1:0][AW-1:0]  s_awaddr;
  logic [N-1:0][7:0]     s_awlen;
  logic [N-1:0][DW-1:0]  s_wdata;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, grant_valid, err_wlast;
  logic [IW:0]     m_awid;
  logic [AW-1:0]   m_awaddr;
  logic [7:0]      m_awlen;
  logic [DW-1:0]   m_wdata;
  logic [0:0]      grant_idx;

  logic [N4-1:0]          s4_awvalid, s4_awready, s4_wvalid, s4_wready, s4_wlast;
  logic [N4-1:0][IW-1:0]  s4_awid;
  logic [N4-1:0][AW-1:0]  s4_awaddr;
  logic [N4-1:0][7:0]     s4_awlen;
  logic [N4-1:0][DW4-1:0] s4_wdata;
  logic m4_awvalid, m4_awready, m4_wvalid, m4_wready, m4_wlast, m4_gv, m4_err;
  logic [IW+1:0]   m4_awid;
  logic [AW-1:0]   m4_awaddr;
  logic [7:0]      m4_awlen;
  logic [DW4-1:0]  m4_wdata;
  logic [1:0]      m4_grant;

  axi_wr_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid_i(s_awvalid), .s_awready_o(s_awready), .s_awid_i(s_awid), .s_awaddr_i(s_awaddr),
    .s_awlen_i(s_awlen), .s_wvalid_i(s_wvalid), .s_wready_o(s_wready), .s_wdata_i(s_wdata),
    .s_wlast_i(s_wlast), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready), .m_awid_o(m_awid),
    .m_awaddr_o(m_awaddr), .m_awlen_o(m_awlen), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_wdata_o(m_wdata), .m_wlast_o(m_wlast), .grant_valid_o(grant_valid),
    .grant_idx_o(grant_idx), .err_wlast_o(err_wlast)
  );

  axi_wr_arbiter #(.NUM_REQ(N4), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid_i(s4_awvalid), .s_awready_o(s4_awready), .s_awid_i(s4_awid), .s_awaddr_i(s4_awaddr),
    .s_awlen_i(s4_awlen), .s_wvalid_i(s4_wvalid), .s_wready_o(s4_wready), .s_wdata_i(s4_wdata),
    .s_wlast_i(s4_wlast), .m_awvalid_o(m4_awvalid), .m_awready_i(m4_awready), .m_awid_o(m4_awid),
    .m_awaddr_o(m4_awaddr), .m_awlen_o(m4_awlen), .m_wvalid_o(m4_wvalid), .m_wready_i(m4_wready),
    .m_wdata_o(m4_wdata), .m_wlast_o(m4_wlast), .grant_valid_o(m4_gv),
    .grant_idx_o(m4_grant), .err_wlast_o(m4_err)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    return {8{(32'hD0D0_0000 | 32'(k))}};
  endfunction

  initial begin
    int k, cyc, early;
    logic hs;
    int exp4 [4];
    exp4 = '{3, 0, 1, 2};
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_awid = '0; s_awaddr = '0;
    s_awlen = '0; s_wdata = '0; m_awready = 1'b1; m_wready = 1'b1;
    s4_awvalid = '0; s4_wvalid = '0; s4_wlast = '0; s4_awid = '0; s4_awaddr = '0;
    s4_awlen = '0; s4_wdata = '0; m4_awready = 1'b1; m4_wready = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_gv", grant_valid, 0);
    chk("rst_valids", {m_awvalid, m_wvalid}, 0);
    chk("rst_readys", {s_awready, s_wready}, 0);
    chk("rst_err", err_wlast, 0);
    chk("rst_gidx", grant_idx, 0);
    step();
    rst_n = 1'b1;

    // single burst, port 0, awlen 3
    s_awid[0] = 4'hA; s_awaddr[0] = 32'h1000; s_awlen[0] = 8'd3; s_awvalid = 2'b01;
    @(negedge clk);
    chk("t1_idle_awvalid", m_awvalid, 0);
    chk("t1_idle_awready", s_awready, 0);
    step();
    @(negedge clk);
    chk("t1_awvalid", m_awvalid, 1);
    chk("t1_awid", m_awid, 5'h0A);
    chk("t1_awaddr", m_awaddr, 32'h1000);
    chk("t1_awlen", m_awlen, 3);
    chk("t1_awready", s_awready, 2'b01);
    chk("t1_gv", grant_valid, 1);
    step();
    s_awvalid = '0; s_wvalid = 2'b01;
    for (int b = 0; b < 4; b++) begin
      s_wdata[0] = pat(b); s_wlast[0] = (b == 3);
      @(negedge clk);
      if (b == 0) chk("t1_no_awvalid_in_data", m_awvalid, 0);
      chk("t1_wvalid", m_wvalid, 1);
      chk("t1_wdata", m_wdata == pat(b), 1);
      chk("t1_wlast", m_wlast, (b == 3));
      chk("t1_wready", s_wready, 2'b01);
      step();
    end
    s_wvalid = '0; s_wlast = '0;
    @(negedge clk);
    chk("t1_done_gv", grant_valid, 0);
    chk("t1_err", err_wlast, 0);
    step();

    // both ports, awlen 0: rr_ptr is 1 so grants run 1,0,1,0
    s_awid[1] = 4'h5; s_awaddr[1] = 32'h2000; s_awlen = '0;
    s_awvalid = 2'b11; s_wvalid = 2'b11; s_wlast = 2'b11;
    for (int b = 0; b < 4; b++) begin
      int g;
      g = (b % 2 == 0) ? 1 : 0;
      @(negedge clk);
      chk("t2_bubble", grant_valid, 0);
      step();
      @(negedge clk);
      chk("t2_grant", grant_idx, g);
      chk("t2_awid", m_awid, (g == 1) ? 5'h15 : 5'h0A);
      step();
      @(negedge clk);
      chk("t2_wlast", m_wlast, 1);
      chk("t2_wready", s_wready, (g == 1) ? 2'b10 : 2'b01);
      if (b == 3) s_awvalid = '0;
      step();
    end
    s_wvalid = '0; s_wlast = '0;

    // port 1 raises s_wlast early on beat 2 of awlen 3
    s_awlen[1] = 8'd3; s_awvalid = 2'b10;
    @(negedge clk);
    chk("t3_idle", grant_valid, 0);
    step();
    @(negedge clk);
    chk("t3_grant", grant_idx, 1);
    chk("t3_awlen", m_awlen, 3);
    step();
    s_awvalid = '0; s_wvalid = 2'b10;
    for (int b = 0; b < 4; b++) begin
      s_wdata[1] = pat(b + 16); s_wlast[1] = (b == 1);
      @(negedge clk);
      chk("t3_wlast", m_wlast, (b == 3));
      chk("t3_err", err_wlast, (b >= 2));
      step();
    end
    s_wvalid = '0; s_wlast = '0;
    @(negedge clk);
    chk("t3_err_sticky", err_wlast, 1);
    chk("t3_done_gv", grant_valid, 0);
    step();

    // backpressure: m_wready 1010 over an awlen 7 burst on port 0
    s_awlen[0] = 8'd7; s_awvalid = 2'b01;
    step();
    @(negedge clk);
    chk("t4_grant", grant_idx, 0);
    step();
    s_awvalid = '0; s_wvalid = 2'b01; s_wdata[0] = pat(0); s_wlast[0] = 1'b0;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 40) begin
      m_wready = (cyc % 2 == 0);
      @(negedge clk);
      chk("t4_sready", s_wready, {1'b0, m_wready});
      hs = m_wvalid && m_wready;
      if (hs) begin
        chk("t4_wdata", m_wdata == pat(k), 1);
        chk("t4_wlast", m_wlast, (k == 7));
      end
      step();
      if (hs) begin
        k++;
        s_wdata[0] = pat(k); s_wlast[0] = (k == 7);
      end
      cyc++;
    end
    chk("t4_beats", k, 8);
    s_wvalid = '0; s_wlast = '0; m_wready = 1'b1;
    @(negedge clk);
    chk("t4_done_gv", grant_valid, 0);
    step();

    // reset mid-DATA after two beats of a port-1 burst
    s_awlen[1] = 8'd3; s_awvalid = 2'b10;
    step();
    @(negedge clk);
    chk("t5_grant", grant_idx, 1);
    step();
    s_awvalid = '0; s_wvalid = 2'b10; s_wlast = '0;
    step();
    step();
    rst_n = 1'b0; s_awvalid = 2'b11;
    @(negedge clk);
    chk("t5_rst_valids", {m_awvalid, m_wvalid}, 0);
    chk("t5_rst_readys", {s_awready, s_wready}, 0);
    chk("t5_rst_gv", grant_valid, 0);
    chk("t5_rst_err", err_wlast, 0);
    step();
    step();
    rst_n = 1'b1; s_wvalid = '0;
    @(negedge clk);
    chk("t5_idle", grant_valid, 0);
    step();
    @(negedge clk);
    chk("t5_rrptr0", grant_idx, 0);
    chk("t5_gv", grant_valid, 1);
    s_awvalid = '0;
    step();

    // 4-port: awlen 255 burst on port 2, then everyone requests
    s4_awlen[2] = 8'd255; s4_awid[2] = 4'h7; s4_awvalid = 4'b0100;
    step();
    @(negedge clk);
    chk("t6_awlen", m4_awlen, 255);
    chk("t6_grant", m4_grant, 2);
    chk("t6_awid", m4_awid, 6'h27);
    step();
    s4_awvalid = '0; s4_wvalid = 4'b0100;
    early = 0;
    for (int b = 0; b < 256; b++) begin
      s4_wdata[2] = 32'(b); s4_wlast[2] = (b == 255);
      @(negedge clk);
      if (b < 255 && m4_wlast) early++;
      if (b == 200) chk("t6_wdata", m4_wdata, 200);
      if (b == 255) chk("t6_last", m4_wlast, 1);
      step();
    end
    chk("t6_early_last", early, 0);
    chk("t6_err", m4_err, 0);
    s4_wvalid = '0; s4_wlast = '0;
    @(negedge clk);
    chk("t6_done_gv", m4_gv, 0);
    step();

    s4_awlen = '0; s4_awvalid = 4'hF; s4_wvalid = 4'hF; s4_wlast = 4'hF;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("t6_bubble", m4_gv, 0);
      step();
      @(negedge clk);
      chk("t6_rr_grant", m4_grant, exp4[b]);
      step();
      @(negedge clk);
      chk("t6_rr_wlast", m4_wlast, 1);
      if (b == 3) s4_awvalid = '0;
      step();
    end
    s4_wvalid = '0; s4_wlast = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
